beep_sequencer: RTL
===================

// Module: beep_sequencer
// PURPOSE
//  Parametrised successor to the timer's alarm beeper. It generates the audio square wave internally
//  from the system clock, with two selectable tones. It plays single, N-burst or continuous on/off
//  patterns with programmable on/off durations. Sits between timer control logic (start/stop
//  requests) and the buzzer pin.
// PARAMETERS
//  CLK_HZ     100_000_000  system clock frequency
//  TONE_LO_HZ 512          tone when tone_sel=0
//  TONE_HI_HZ 1024         tone when tone_sel=1
//  TICK_HZ    1000         duration tick rate (1 ms); TICK_DIV = CLK_HZ/TICK_HZ clocks per tick
//  DUR_W      10           width of on/off duration ports (ticks)
//  BURST_W    4            width of burst count port
// PORTS
//  clk      in  1        system clock
//  rst      in  1        asynchronous reset, active-high
//  start    in  1        1-cycle request to begin a pattern
//  stop     in  1        abort; level or pulse
//  tone_sel in  1        0 = TONE_LO_HZ, 1 = TONE_HI_HZ
//  mode     in  2        00 single, 01 burst, 10 continuous, 11 = single
//  burst_n  in  BURST_W  number of beeps in burst mode (0 treated as 1)
//  on_ticks  in  DUR_W   beep-on duration in ticks (0 treated as 1)
//  off_ticks in  DUR_W   gap duration in ticks (0 treated as 1)
//  beep     out 1        square-wave buzzer drive
//  busy     out 1        high while state != IDLE
//  done     out 1        1-cycle pulse on normal completion
// BEHAVIOUR
//  - Reset: state=IDLE; beep=0, busy=0, done=0; all counters=0. Reset mid-pattern aborts immediately.
//  - Input latching: tone_sel, mode, burst_n, on_ticks and off_ticks are latched on the accepted start edge.
//    Later input changes have no effect until the next start.
//  - Start acceptance: start is accepted only in IDLE and only when stop=0. A start while busy is ignored.
//  - Tone generation: HALF = CLK_HZ/(2*tone_hz), integer-truncated. In ON, beep toggles every HALF clocks.
//    On entry to ON, beep=1 and the tone counter is 0. In every other state, beep=0.
//  - Duration timing: a prescaler and a tick counter both restart at 0 on every state entry.
//    ON lasts exactly on_ticks*TICK_DIV clocks; OFF lasts exactly off_ticks*TICK_DIV clocks.
//  - FSM states: IDLE, ON, OFF.
//    IDLE -start-> ON (same edge: busy=1, beep=1, beep counter=1).
//    ON end: if the pattern is complete, go to IDLE and pulse done=1 on that edge.
//            Otherwise go to OFF.
//    OFF end: go to ON and increment the beep counter.
//  - Completion rules:
//    single: complete after the 1st ON.
//    burst: complete after ON number burst_n. There is no trailing OFF.
//    continuous: never completes and never pulses done.
//  - Stop: stop=1 in any non-IDLE state forces IDLE on the next edge (beep=0, busy=0, no done).
//    If stop and the ON-end event occur on the same cycle, stop wins and done is not pulsed.
//  - Restart: done and IDLE coincide, so a start on the following cycle is accepted.
//  - Widths: duration counters are DUR_W bits and never wrap.
//    The beep counter is BURST_W bits; burst_n=2^BURST_W-1 is supported.
// TESTING
//  Use CLK_HZ=16384, TICK_HZ=1024 (TICK_DIV=16), TONE_LO=512 (HALF=16), TONE_HI=1024 (HALF=8).
//  1. rst pulse mid-ON -> beep=0, busy=0 immediately (asynchronous); no done afterwards.
//  2. Single, tone_sel=1, on_ticks=2 -> beep high 8 clks, low 8, high 8, low 8 (32 clks).
//     Then busy=0 and a done pulse on the same edge; beep stays 0.
//  3. Burst, burst_n=3, on=1, off=2, tone 0 -> 3 ON windows of 16 clks separated by 32-clk gaps.
//     Total busy = 112 clks; exactly one done pulse.
//  4. Continuous, on=1, off=1; stop asserted at clk 100 -> IDLE at clk 101, beep=0, no done.
//     Also stop coincident with the ON-end of a single pattern -> no done.
//  5. start pulsed while busy, with different mode and tone -> ignored; the running pattern is unchanged.
//     start on the cycle after done -> accepted.
//  6. Zero handling: burst_n=0 and on_ticks=0 -> behaves as a single 16-clk beep.
//     start and stop asserted together in IDLE -> stays IDLE.

Source files
------------

// File: rtl/beep_sequencer_if.sv
// Control/status bundle between the timer control logic and the beep sequencer.
// The controller drives requests and pattern settings; the sequencer returns
// the buzzer drive and its status flags.
interface beep_sequencer_if #(
    parameter int DUR_W   = 10,
    parameter int BURST_W = 4
);
    logic               start;
    logic               stop;
    logic               tone_sel;
    logic [1:0]         mode;
    logic [BURST_W-1:0] burst_n;
    logic [DUR_W-1:0]   on_ticks;
    logic [DUR_W-1:0]   off_ticks;
    logic               beep;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, tone_sel, mode, burst_n, on_ticks, off_ticks,
        input  beep, busy, done
    );

    modport slave (
        input  start, stop, tone_sel, mode, burst_n, on_ticks, off_ticks,
        output beep, busy, done
    );
endinterface

// File: rtl/beep_sequencer.sv
// Beep pattern sequencer: single / burst / continuous on-off patterns with an
// internally generated square-wave tone. Durations are counted in ticks of
// CLK_HZ/TICK_HZ clocks; all pattern settings are captured when a start is accepted.
module beep_sequencer #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TONE_LO_HZ = 512,
    parameter int TONE_HI_HZ = 1024,
    parameter int TICK_HZ    = 1000,
    parameter int DUR_W      = 10,
    parameter int BURST_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    beep_sequencer_if.slave  bus
);

    // Clocks per duration tick, and prescaler width (at least one bit).
    localparam int TICK_DIV = (CLK_HZ / TICK_HZ < 1) ? 1 : CLK_HZ / TICK_HZ;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Half-period of each tone in clocks, clamped to 1 so a tone never stalls.
    localparam int HALF_LO_RAW = CLK_HZ / (2 * TONE_LO_HZ);
    localparam int HALF_HI_RAW = CLK_HZ / (2 * TONE_HI_HZ);
    localparam int HALF_LO     = (HALF_LO_RAW < 1) ? 1 : HALF_LO_RAW;
    localparam int HALF_HI     = (HALF_HI_RAW < 1) ? 1 : HALF_HI_RAW;
    localparam int HALF_MAX    = (HALF_LO > HALF_HI) ? HALF_LO : HALF_HI;
    localparam int TW          = $clog2(HALF_MAX + 1);

    localparam logic [PW-1:0] PRE_LAST     = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] HALF_LO_LAST = TW'(HALF_LO - 1);
    localparam logic [TW-1:0] HALF_HI_LAST = TW'(HALF_HI - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    state_t state, state_nx;

    // Timing counters: both restart at zero on every state entry.
    logic [PW-1:0]      pre;
    logic [DUR_W-1:0]   tick;

    // Tone generator.
    logic [TW-1:0]      tone_cnt;
    logic               beep_r;

    // Pattern progress and captured settings. Durations and burst length are
    // stored already zero-corrected, durations as "last tick index" (n-1).
    logic [BURST_W-1:0] beep_cnt;
    logic [BURST_W-1:0] burst_last;
    logic [DUR_W-1:0]   on_last;
    logic [DUR_W-1:0]   off_last;
    logic               cont_lat;
    logic               tone_lat;
    logic               done_r;

    // Derived events.
    logic               tick_end;
    logic               on_end;
    logic               off_end;
    logic               complete;
    logic               accept;
    logic               busy_c;
    logic               done_set;
    logic               enter_on;
    logic [TW-1:0]      tone_last;

    assign tick_end  = (pre == PRE_LAST);
    assign on_end    = (state == ON)  && tick_end && (tick == on_last);
    assign off_end   = (state == OFF) && tick_end && (tick == off_last);
    assign complete  = !cont_lat && (beep_cnt == burst_last);
    assign tone_last = tone_lat ? HALF_HI_LAST : HALF_LO_LAST;
    assign enter_on  = (state_nx == ON) && (state != ON);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; stop always wins over the end of an ON or OFF window.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (bus.start && !bus.stop) state_nx = ON;
            ON: begin
                if (bus.stop)    state_nx = IDLE;
                else if (on_end) state_nx = complete ? IDLE : OFF;
            end
            OFF: begin
                if (bus.stop)     state_nx = IDLE;
                else if (off_end) state_nx = ON;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output/event decode from the current state.
    always_comb begin
        busy_c   = (state != IDLE);
        accept   = (state == IDLE) && bus.start && !bus.stop;
        done_set = on_end && !bus.stop && complete;
    end

    // Prescaler and tick counter; cleared on every transition and while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre  <= '0;
            tick <= '0;
        end else if (state_nx != state || state == IDLE) begin
            pre  <= '0;
            tick <= '0;
        end else if (tick_end) begin
            pre  <= '0;
            tick <= tick + DUR_W'(1);
        end else begin
            pre  <= pre + PW'(1);
        end
    end

    // Square wave: high on ON entry, toggles every half period, low elsewhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beep_r   <= 1'b0;
            tone_cnt <= '0;
        end else if (enter_on) begin
            beep_r   <= 1'b1;
            tone_cnt <= '0;
        end else if (state_nx == ON) begin
            if (tone_cnt == tone_last) begin
                tone_cnt <= '0;
                beep_r   <= ~beep_r;
            end else begin
                tone_cnt <= tone_cnt + TW'(1);
            end
        end else begin
            beep_r   <= 1'b0;
            tone_cnt <= '0;
        end
    end

    // Beep counter: 1 on start, +1 on each OFF->ON, cleared when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beep_cnt <= '0;
        end else if (accept) begin
            beep_cnt <= BURST_W'(1);
        end else if (state == OFF && state_nx == ON) begin
            beep_cnt <= beep_cnt + BURST_W'(1);
        end else if (state_nx == IDLE) begin
            beep_cnt <= '0;
        end
    end

    // Capture pattern settings on an accepted start; single mode is a burst of one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_last <= '0;
            on_last    <= '0;
            off_last   <= '0;
            cont_lat   <= 1'b0;
            tone_lat   <= 1'b0;
        end else if (accept) begin
            tone_lat <= bus.tone_sel;
            cont_lat <= (bus.mode == 2'b10);
            if (bus.mode == 2'b01 && bus.burst_n != '0) burst_last <= bus.burst_n;
            else                                        burst_last <= BURST_W'(1);
            on_last  <= (bus.on_ticks  == '0) ? '0 : bus.on_ticks  - DUR_W'(1);
            off_last <= (bus.off_ticks == '0) ? '0 : bus.off_ticks - DUR_W'(1);
        end
    end

    // One-cycle completion pulse, registered on the ON->IDLE edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) done_r <= 1'b0;
        else     done_r <= done_set;
    end

    assign bus.beep = beep_r;
    assign bus.busy = busy_c;
    assign bus.done = done_r;

endmodule
